// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - start/busy/done handshake, operands, HI/LO results and move-to write port
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiply / restoring divide into HI/LO
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_a_orig;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_busy;
    logic             w_accept;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_mul_add;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_div_ok;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;

    // Operand conditioning: signed ops (op[0]==0) work on magnitudes.
    assign w_signed = ~bus.op[0];
    assign w_a_neg  = w_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag  = w_b_neg ? -bus.b : bus.b;

    // Multiply step: add multiplicand when the low multiplier bit is set, then shift right.
    assign w_mul_add = r_mq[0] ? r_opb : '0;
    assign w_mul_sum = {1'b0, r_acc} + {1'b0, w_mul_add};

    // Divide step: shift in next dividend bit and trial-subtract the divisor.
    assign w_div_shift = {r_acc, r_mq[WIDTH-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opb};
    assign w_div_ok    = ~w_div_diff[WIDTH+1];

    assign w_prod     = {r_acc, r_mq};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = S_CALC;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_busy = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand latch, one iteration per CALC cycle, sign fix and HI/LO update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_orig   <= '0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_mq       <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_div   <= bus.op[1];
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= (bus.b == '0);
                        r_a_orig   <= bus.a;
                        r_mq       <= w_a_mag;
                        r_opb      <= w_b_mag;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                    end else begin
                        // Move-to writes only land when no operation is being launched.
                        if (bus.wr_hi) begin
                            r_hi <= bus.wr_data;
                        end
                        if (bus.wr_lo) begin
                            r_lo <= bus.wr_data;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_acc <= w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
                        r_mq  <= {r_mq[WIDTH-2:0], w_div_ok};
                    end else begin
                        r_acc <= w_mul_sum[WIDTH:1];
                        r_mq  <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        if (r_div_zero) begin
                            // Divide by zero reports the raw dividend, not a sign-fixed magnitude.
                            r_hi <= r_a_orig;
                            r_lo <= '1;
                        end else begin
                            r_lo <= r_neg_q ? -r_mq : r_mq;
                            r_hi <= r_neg_r ? -r_acc : r_acc;
                        end
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide unit for the integer execute stage.
- Writes a 64-bit result into architectural HI/LO registers.
- Its hi and lo outputs feed directly into the downstream 2:1 32-bit selector that picks HI or LO for writeback, so both outputs are registered and stable whenever the unit is not busy.
- Provides a start/busy/done handshake to the pipeline stall logic, plus direct HI/LO write ports for move-to instructions.

Parameters:
- WIDTH, 32, operand width. Only 32 is required to be supported. The cycle counter is sized clog2(WIDTH)+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  launch operation; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  input  32  multiplicand / dividend
- b  input  32  multiplier / divisor
- wr_hi  input  1  write wr_data into HI
- wr_lo  input  1  write wr_data into LO
- wr_data  input  32  move-to data
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- hi  output  32  HI register: product[63:32] or remainder
- lo  output  32  LO register: product[31:0] or quotient

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared.
- Reset mid-operation aborts the operation with no partial result; same outputs as reset.
- States:
  - IDLE: start=1 latches op and a, b.
    - Signed ops store operand magnitudes and result-sign flags.
    - Clears the accumulator and counter, then goes to CALC.
  - CALC: exactly 32 cycles, one bit per cycle.
    - Multiply: shift-add.
    - Divide: restoring, one quotient bit per cycle.
    - After the 32nd iteration goes to FIX.
  - FIX: applies two's-complement sign correction, writes hi/lo, sets done for the next cycle, returns to IDLE.
- Latency: start sampled at edge E0; hi/lo updated and done=1 at edge E33. done is high for exactly one cycle.
- busy: 1 from the edge after start through the FIX cycle; 0 in IDLE.
- start:
  - Ignored while busy.
  - A start in the same cycle as done=1 is accepted, since the state is already IDLE.
- wr_hi / wr_lo:
  - Take effect at the next edge only when the state is IDLE and start=0.
  - Ignored while busy, and dropped when coincident with an accepted start.
  - Both may assert together.
- hi/lo hold their value at all other times; no intermediate values are visible.
- Result rules:
  - MULT/MULTU: {hi,lo} = full 64-bit product, signed or unsigned.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Boundary cases:
  - Divide by zero (both DIV and DIVU): lo=32'hFFFFFFFF, hi=a. Still takes the full 34-cycle latency.
  - DIV overflow (a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0.
  - Multiply of 32'h80000000 by itself is signed-correct: MULT gives 64'h4000000000000000.
- op and operand changes after the start cycle have no effect on the running operation.

Test Plan:
- Reset, then idle: hi=0, lo=0, busy=0, done=0. Assert rst during CALC at cycle 10 of MULTU 5*7: outputs return to reset values the next cycle and no done pulse follows.
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF: done exactly 34 cycles after start; hi=32'hFFFFFFFE, lo=32'h00000001. MULT with a=-3, b=7: hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
- DIV a=-7, b=2: lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). DIVU a=100, b=7: lo=14, hi=2.
- DIV a=32'h80000000, b=-1: lo=32'h80000000, hi=0. DIVU a=1234, b=0: lo=32'hFFFFFFFF, hi=1234, latency still 34.
- Handshake:
  - Pulse start again at cycles 5 and 20 of a run: ignored, original result intact.
  - Back-to-back start in the done cycle: accepted, second done 34 cycles later.
  - wr_hi=1, wr_data=32'hDEADBEEF while busy: hi unchanged. Same write while idle: hi=32'hDEADBEEF next cycle.
- Concurrent idle write and start: wr_lo with start MULTU 2*3 in the same cycle: write dropped; final lo=6, hi=0.
